golden_nonce_filter: RTL and testbench

- Sits directly downstream of the double-SHA finisher and consumes its accepted pulse, final hash and nonce.
- Discards pipeline warm-up results after reset or new work.
- Tests each hash against a share target and queues qualifying (golden) nonces in a small FIFO, drained by a valid/ready handshake toward the host link.
- Keeps saturating statistics counters.

---
 rtl/golden_nonce_filter_pkg.sv | 35 +++
 rtl/golden_nonce_filter_if.sv | 36 +++
 rtl/golden_nonce_filter_nonce_fifo.sv | 78 +++++++
 rtl/golden_nonce_filter.sv | 131 +++++++++++++
 tb/tb_golden_nonce_filter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/golden_nonce_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : golden_nonce_filter_pkg
// Purpose  : Shared types, constants and helpers for the golden-nonce filter.
//            - SHA word positions inside the 256-bit finisher hash
//            - byte swap between hash byte order and SHA word order
//            - saturating-counter increment enable
//            - FIFO entry layout {nonce, h6}
// Revision : 1.0 - initial release
// ============================================================================
package golden_nonce_filter_pkg;

  localparam int WORD_W  = 32;
  localparam int H6_LSB  = 192;
  localparam int H7_LSB  = 224;
  localparam int ENTRY_W = 2 * WORD_W;

  // One FIFO entry: the golden nonce and the H6 word it produced.
  typedef struct packed {
    logic [WORD_W-1:0] nonce;
    logic [WORD_W-1:0] h6;
  } golden_entry_t;

  // Converts a hash word as delivered by the finisher into SHA word order.
  function automatic logic [WORD_W-1:0] byteswap32(input logic [WORD_W-1:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Increment enable for a counter that must stick at all-ones.
  function automatic logic sat_inc_en(input logic inc, input logic at_max);
    return inc & ~at_max;
  endfunction

endpackage
`default_nettype wire

// File: rtl/golden_nonce_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : golden_nonce_filter_if
// Purpose  : Valid/ready stream carrying golden nonces toward the host link.
//            Ports (signals):
//              out_valid - FIFO head available
//              out_ready - consumer accepts head
//              out_nonce - golden nonce at FIFO head
//              out_h6    - H6 word of that hash (SHA word order)
//            master: the filter (drives valid/data), slave: the consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface golden_nonce_filter_if;
  import golden_nonce_filter_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_nonce;
  logic [WORD_W-1:0] out_h6;

  modport master (
    output out_valid,
    output out_nonce,
    output out_h6,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_nonce,
    input  out_h6,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/golden_nonce_filter_nonce_fifo.sv
`default_nettype none
// ============================================================================
// Module   : golden_nonce_filter_nonce_fifo
// Purpose  : Show-ahead circular FIFO with simultaneous push/pop support.
//            Ports:
//              clk, rst  - clock, synchronous active-high reset
//              push_i    - write data_i (ignored when full without a pop)
//              data_i    - entry to write
//              pop_i     - consumer ready; pops only when not empty
//              data_o    - head entry, zero while empty
//              valid_o   - FIFO not empty
//              full_o    - FIFO holds DEPTH entries
// Revision : 1.0 - initial release
// ============================================================================
module golden_nonce_filter_nonce_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  typedef logic [AW:0] ptr_t;

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  always_comb begin
    w_empty   = (wr_ptr_q == rd_ptr_q);
    w_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    w_do_pop  = pop_i && !w_empty;
    // A push into a full FIFO is legal when the head leaves on the same edge.
    w_do_push = push_i && (!w_full || w_do_pop);
    wr_ptr_d  = wr_ptr_q + ptr_t'(w_do_push);
    rd_ptr_d  = rd_ptr_q + ptr_t'(w_do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  always_comb begin
    data_o  = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    valid_o = !w_empty;
    full_o  = w_full;
  end

endmodule
`default_nettype wire

// File: rtl/golden_nonce_filter.sv
`default_nettype none
// ============================================================================
// Module   : golden_nonce_filter
// Purpose  : Filters double-SHA finisher results for shares. Drops warm-up
//            results after reset/new work, tests H7==0 and H6<=share target,
//            queues golden {nonce,h6} in a FIFO and keeps saturating stats.
//            Ports:
//              clk, rst          - clock, synchronous active-high reset
//              new_work_i        - upstream work changed; restart warm-up skip
//              share_target_i    - max H6 (SHA word order) for a golden result
//              in_accepted_i     - finisher result strobe
//              in_hash_i         - hash, valid the cycle after the strobe
//              in_nonce_i        - nonce for in_hash_i
//              out_if            - golden nonce stream (master)
//              hashes_checked_o  - results evaluated after the skip window
//              golden_count_o    - results pushed into the FIFO
//              drop_count_o      - golden results lost to a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module golden_nonce_filter
  import golden_nonce_filter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int SKIP_RESULTS = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_work_i,
  input  logic [WORD_W-1:0]     share_target_i,
  input  logic                  in_accepted_i,
  input  logic [255:0]          in_hash_i,
  input  logic [WORD_W-1:0]     in_nonce_i,
  golden_nonce_filter_if.master out_if,
  output logic [CNT_W-1:0]      hashes_checked_o,
  output logic [CNT_W-1:0]      golden_count_o,
  output logic [CNT_W-1:0]      drop_count_o
);

  localparam int SKIP_W = (SKIP_RESULTS < 1) ? 1 : $clog2(SKIP_RESULTS + 1);
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(SKIP_RESULTS);

  logic              acc_q;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [CNT_W-1:0]  checked_q, checked_d;
  logic [CNT_W-1:0]  golden_q, golden_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [WORD_W-1:0] w_h7;
  logic [WORD_W-1:0] w_h6;
  logic              w_golden;
  logic              w_live;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_fifo_valid;
  logic              w_fifo_full;
  golden_entry_t     w_entry;
  golden_entry_t     w_head;
  logic              w_unused_hash;

  // Only H6/H7 take part in the share test.
  assign w_unused_hash = ^in_hash_i[H6_LSB-1:0];

  always_comb begin
    w_h7     = in_hash_i[H7_LSB +: WORD_W];
    w_h6     = byteswap32(in_hash_i[H6_LSB +: WORD_W]);
    w_golden = (w_h7 == '0) && (w_h6 <= share_target_i);
    // A result coinciding with new_work belongs to the old work: ignore it.
    w_live   = acc_q && !new_work_i && (skip_q == '0);
    w_pop    = w_fifo_valid && out_if.out_ready;
    w_push   = w_live && w_golden && (!w_fifo_full || w_pop);
    w_drop   = w_live && w_golden && w_fifo_full && !w_pop;
    w_entry  = '{nonce: in_nonce_i, h6: w_h6};
  end

  always_comb begin
    skip_d = skip_q;
    if (new_work_i) begin
      skip_d = SKIP_LOAD;
    end else if (acc_q && (skip_q != '0)) begin
      skip_d = skip_q - 1'b1;
    end
  end

  always_comb begin
    checked_d = checked_q + CNT_W'(sat_inc_en(w_live, &checked_q));
    golden_d  = golden_q  + CNT_W'(sat_inc_en(w_push, &golden_q));
    drop_d    = drop_q    + CNT_W'(sat_inc_en(w_drop, &drop_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= 1'b0;
      skip_q    <= SKIP_LOAD;
      checked_q <= '0;
      golden_q  <= '0;
      drop_q    <= '0;
    end else begin
      acc_q     <= in_accepted_i;
      skip_q    <= skip_d;
      checked_q <= checked_d;
      golden_q  <= golden_d;
      drop_q    <= drop_d;
    end
  end

  golden_nonce_filter_nonce_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (w_entry),
    .pop_i   (out_if.out_ready),
    .data_o  (w_head),
    .valid_o (w_fifo_valid),
    .full_o  (w_fifo_full)
  );

  assign out_if.out_valid = w_fifo_valid;
  assign out_if.out_nonce = w_head.nonce;
  assign out_if.out_h6    = w_head.h6;

  assign hashes_checked_o = checked_q;
  assign golden_count_o   = golden_q;
  assign drop_count_o     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_golden_nonce_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_golden_nonce_filter
// Purpose  : Directed self-checking bench for golden_nonce_filter. A second
//            instance with 4-bit counters shares the stimulus so counter
//            saturation is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_golden_nonce_filter;

  logic         clk = 1'b0;
  logic         rst;
  logic         new_work;
  logic         in_accepted;
  logic         ready;
  logic [31:0]  share_target;
  logic [31:0]  in_nonce;
  logic [255:0] in_hash;
  logic [31:0]  hc, gc, dc;
  logic [3:0]   hc4, gc4, dc4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  golden_nonce_filter_if out_if ();
  golden_nonce_filter_if sat_if ();

  assign out_if.out_ready = ready;
  assign sat_if.out_ready = ready;

  golden_nonce_filter #(
    .FIFO_DEPTH   (4),
    .SKIP_RESULTS (2),
    .CNT_W        (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .new_work_i       (new_work),
    .share_target_i   (share_target),
    .in_accepted_i    (in_accepted),
    .in_hash_i        (in_hash),
    .in_nonce_i       (in_nonce),
    .out_if           (out_if),
    .hashes_checked_o (hc),
    .golden_count_o   (gc),
    .drop_count_o     (dc)
  );

  golden_nonce_filter #(
    .FIFO_DEPTH   (4),
    .SKIP_RESULTS (2),
    .CNT_W        (4)
  ) dut_sat (
    .clk              (clk),
    .rst              (rst),
    .new_work_i       (new_work),
    .share_target_i   (share_target),
    .in_accepted_i    (in_accepted),
    .in_hash_i        (in_hash),
    .in_nonce_i       (in_nonce),
    .out_if           (sat_if),
    .hashes_checked_o (hc4),
    .golden_count_o   (gc4),
    .drop_count_o     (dc4)
  );

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic counts(input string tag, input int h, input int g, input int d);
    check({tag, " hashes_checked"}, 64'(hc), 64'(h));
    check({tag, " golden_count"},   64'(gc), 64'(g));
    check({tag, " drop_count"},     64'(dc), 64'(d));
  endtask

  // Strobe, then present the hash in the evaluate cycle; returns 1ns after
  // the evaluate edge so the registered effect is visible.
  task automatic send(input logic [31:0] nonce, input logic [31:0] h7,
                      input logic [31:0] h6, input logic pop_now, input logic nw);
    @(posedge clk); #1;
    in_accepted = 1'b1;
    @(posedge clk); #1;
    in_accepted = 1'b0;
    in_hash     = {h7, bswap(h6), {6{nonce}}};
    in_nonce    = nonce;
    ready       = pop_now;
    new_work    = nw;
    @(posedge clk); #1;
    ready    = 1'b0;
    new_work = 1'b0;
    in_hash  = '0;
    in_nonce = '0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] nonce, input logic [31:0] h6);
    check({tag, " out_valid"}, 64'(out_if.out_valid), 64'd1);
    check({tag, " out_nonce"}, 64'(out_if.out_nonce), 64'(nonce));
    check({tag, " out_h6"},    64'(out_if.out_h6),    64'(h6));
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    new_work     = 1'b0;
    in_accepted  = 1'b0;
    in_hash      = '0;
    in_nonce     = '0;
    ready        = 1'b0;
    share_target = 32'h0000_FFFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset out_valid", 64'(out_if.out_valid), 64'd0);
    check("reset out_nonce", 64'(out_if.out_nonce), 64'd0);
    check("reset out_h6",    64'(out_if.out_h6),    64'd0);
    counts("reset", 0, 0, 0);

    // Warm-up skip: first two results discarded
    send(32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
    send(32'h11, 32'h0, 32'h0, 1'b0, 1'b0);
    send(32'h12, 32'h0, 32'h0, 1'b0, 1'b0);
    counts("warmup", 1, 1, 0);
    pop_expect("warmup", 32'h12, 32'h0);
    check("warmup empty", 64'(out_if.out_valid), 64'd0);

    // Target compare boundaries
    send(32'h20, 32'h0, 32'h0000_FFFF, 1'b0, 1'b0);
    send(32'h21, 32'h0, 32'h0001_0000, 1'b0, 1'b0);
    send(32'h22, 32'h1, 32'h0, 1'b0, 1'b0);
    counts("target", 4, 2, 0);
    pop_expect("target", 32'h20, 32'h0000_FFFF);
    check("target empty", 64'(out_if.out_valid), 64'd0);

    // Fill past depth with no consumer: fifth is dropped
    for (int i = 0; i < 5; i++) send(32'hA0 + i, 32'h0, 32'h100 + i, 1'b0, 1'b0);
    counts("full", 9, 6, 1);
    for (int i = 0; i < 4; i++) pop_expect($sformatf("drainA%0d", i), 32'hA0 + i, 32'h100 + i);
    check("full drained", 64'(out_if.out_valid), 64'd0);

    // Full FIFO with a pop in the evaluate cycle: push still lands
    for (int i = 0; i < 4; i++) send(32'hC0 + i, 32'h0, 32'h200 + i, 1'b0, 1'b0);
    send(32'hB0, 32'h0, 32'h300, 1'b1, 1'b0);
    counts("fullpop", 14, 11, 1);
    for (int i = 1; i < 4; i++) pop_expect($sformatf("drainC%0d", i), 32'hC0 + i, 32'h200 + i);
    pop_expect("drainB0", 32'hB0, 32'h300);
    check("fullpop drained", 64'(out_if.out_valid), 64'd0);

    // new_work: FIFO retained, coinciding result and next two ignored
    send(32'hD0, 32'h0, 32'h0, 1'b0, 1'b0);
    send(32'hD1, 32'h0, 32'h1, 1'b0, 1'b0);
    counts("pre_nw", 16, 13, 1);
    send(32'hE0, 32'h0, 32'h2, 1'b0, 1'b1);
    send(32'hE1, 32'h0, 32'h3, 1'b0, 1'b0);
    send(32'hE2, 32'h0, 32'h4, 1'b0, 1'b0);
    counts("nw_skip", 16, 13, 1);
    send(32'hE3, 32'h0, 32'h5, 1'b0, 1'b0);
    counts("nw_after", 17, 14, 1);
    pop_expect("nwD0", 32'hD0, 32'h0);
    pop_expect("nwD1", 32'hD1, 32'h1);
    pop_expect("nwE3", 32'hE3, 32'h5);
    check("nw drained", 64'(out_if.out_valid), 64'd0);

    // Reset mid-operation; 4-bit instance has saturated by now
    send(32'hF0, 32'h0, 32'h6, 1'b0, 1'b0);
    send(32'hF1, 32'h0, 32'h7, 1'b0, 1'b0);
    send(32'hF2, 32'h0, 32'h8, 1'b0, 1'b0);
    counts("pre_rst", 20, 17, 1);
    check("sat hashes_checked", 64'(hc4), 64'hF);
    check("sat golden_count",   64'(gc4), 64'hF);
    check("sat drop_count",     64'(dc4), 64'h1);
    check("pre_rst out_valid",  64'(out_if.out_valid), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst out_valid", 64'(out_if.out_valid), 64'd0);
    check("rst out_nonce", 64'(out_if.out_nonce), 64'd0);
    check("rst out_h6",    64'(out_if.out_h6),    64'd0);
    counts("rst", 0, 0, 0);
    check("rst sat hashes_checked", 64'(hc4), 64'd0);
    check("rst sat out_valid", 64'(sat_if.out_valid), 64'd0);

    // Skip window reloaded by reset
    send(32'h60, 32'h0, 32'h9, 1'b0, 1'b0);
    send(32'h61, 32'h0, 32'hA, 1'b0, 1'b0);
    send(32'h62, 32'h0, 32'hB, 1'b0, 1'b0);
    counts("post_rst", 1, 1, 0);
    check("post_rst sat hashes_checked", 64'(hc4), 64'd1);
    check("post_rst sat out_nonce", 64'(sat_if.out_nonce), 64'h62);
    check("post_rst sat out_h6", 64'(sat_if.out_h6), 64'hB);
    pop_expect("post_rst", 32'h62, 32'hB);
    check("post_rst empty", 64'(out_if.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
